// File: rtl/npu_mb_pkg.sv
// Shared register map, STATUS/CTRL bit positions and request record for the NPU mailbox.
package npu_mb_pkg;
    localparam logic [1:0] MB_CMD    = 2'd0;
    localparam logic [1:0] MB_RESULT = 2'd1;
    localparam logic [1:0] MB_STATUS = 2'd2;
    localparam logic [1:0] MB_CTRL   = 2'd3;

    localparam int ST_OVF       = 0;
    localparam int ST_UDF       = 1;
    localparam int ST_CMD_FULL  = 2;
    localparam int ST_RES_EMPTY = 3;
    localparam int ST_CMD_CNT   = 4;
    localparam int ST_RES_CNT   = 11;
    localparam int ST_CNT_W     = 7;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [31:0] MB_UDF_DATA = 32'h0;

    // Bus request captured in the request cycle and committed at the end of the ack cycle.
    typedef struct packed {
        logic [1:0]  op;
        logic        we;
        logic        sel_full;
        logic        pop_ok;
        logic [31:0] wdat;
    } mb_req_t;

    function automatic logic [31:0] mb_status(input logic ovf, input logic udf,
                                              input logic cmd_full, input logic res_empty,
                                              input logic [ST_CNT_W-1:0] cmd_cnt,
                                              input logic [ST_CNT_W-1:0] res_cnt);
        logic [31:0] s;
        s = '0;
        s[ST_OVF]                    = ovf;
        s[ST_UDF]                    = udf;
        s[ST_CMD_FULL]               = cmd_full;
        s[ST_RES_EMPTY]              = res_empty;
        s[ST_CMD_CNT +: ST_CNT_W]    = cmd_cnt;
        s[ST_RES_CNT +: ST_CNT_W]    = res_cnt;
        return s;
    endfunction
endpackage

// File: rtl/mb_sync_fifo.sv
// Synchronous FIFO with registered count; full/empty come from the count at the start of the cycle.
module mb_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push, w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = empty ? '0 : r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end
endmodule

// File: rtl/wb_npu_mailbox.sv
// Wishbone command/result mailbox to the NPU: bus decode, ack, sticky flags, CTRL and interrupt.
module wb_npu_mailbox
    import npu_mb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8,
    parameter int          DATA_W    = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] cmd_data_o,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    input  logic [31:0] res_data_i,
    output logic        irq_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_ack, r_ovf, r_udf, r_irq_en, r_irq;
    logic [31:0]   r_dat;
    mb_req_t       r_req;

    logic          w_sel, w_req, w_wr, w_rd;
    logic          w_cmd_push, w_res_pop, w_ovf_set, w_udf_set, w_st_wr, w_ctrl_wr, w_flush;
    logic          w_cmd_full, w_cmd_empty, w_res_full, w_res_empty;
    logic [CW-1:0] w_cmd_count, w_res_count;
    logic [31:0]   w_res_head, w_rd_data;
    logic          w_unused;

    assign w_unused = &{1'b0, wbs_adr_i[1:0]};

    assign w_sel = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // Requests are blocked while ack is high, so a held strobe acks every second cycle.
    assign w_req = wbs_cyc_i && wbs_stb_i && w_sel && !r_ack;
    assign w_wr  = r_ack && r_req.we;
    assign w_rd  = r_ack && !r_req.we;

    assign w_cmd_push = w_wr && (r_req.op == MB_CMD) && r_req.sel_full;
    assign w_ovf_set  = w_cmd_push && w_cmd_full;
    assign w_res_pop  = w_rd && (r_req.op == MB_RESULT) && r_req.pop_ok;
    assign w_udf_set  = w_rd && (r_req.op == MB_RESULT) && !r_req.pop_ok;
    assign w_st_wr    = w_wr && (r_req.op == MB_STATUS);
    assign w_ctrl_wr  = w_wr && (r_req.op == MB_CTRL);
    assign w_flush    = w_ctrl_wr && r_req.wdat[CTRL_FLUSH];

    assign cmd_valid_o = !w_cmd_empty;
    assign res_ready_o = !w_res_full;
    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign irq_o       = r_irq;

    always_comb begin
        w_rd_data = '0;
        case (wbs_adr_i[3:2])
            MB_RESULT: w_rd_data = w_res_empty ? MB_UDF_DATA : w_res_head;
            MB_STATUS: w_rd_data = mb_status(r_ovf, r_udf, w_cmd_full, w_res_empty,
                                             ST_CNT_W'(w_cmd_count), ST_CNT_W'(w_res_count));
            MB_CTRL:   w_rd_data[CTRL_IRQ_EN] = r_irq_en;
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_req    <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_req.op       <= wbs_adr_i[3:2];
                r_req.we       <= wbs_we_i;
                r_req.sel_full <= (wbs_sel_i == 4'hF);
                // Empty check for a RESULT pop is fixed here so returned data and pop agree.
                r_req.pop_ok   <= !w_res_empty;
                r_req.wdat     <= wbs_dat_i;
                r_dat          <= wbs_we_i ? '0 : w_rd_data;
            end
            if (w_ovf_set)                         r_ovf <= 1'b1;
            else if (w_st_wr && r_req.wdat[ST_OVF]) r_ovf <= 1'b0;
            if (w_udf_set)                         r_udf <= 1'b1;
            else if (w_st_wr && r_req.wdat[ST_UDF]) r_udf <= 1'b0;
            if (w_ctrl_wr) r_irq_en <= r_req.wdat[CTRL_IRQ_EN];
            r_irq <= r_irq_en && !w_res_empty;
        end
    end

    mb_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_cmd_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (w_cmd_push),
        .pop   (cmd_valid_o && cmd_ready_i),
        .flush (w_flush),
        .wdata (r_req.wdat),
        .full  (w_cmd_full),
        .empty (w_cmd_empty),
        .count (w_cmd_count),
        .head  (cmd_data_o)
    );

    mb_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_res_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (res_valid_i && res_ready_o),
        .pop   (w_res_pop),
        .flush (w_flush),
        .wdata (res_data_i),
        .full  (w_res_full),
        .empty (w_res_empty),
        .count (w_res_count),
        .head  (w_res_head)
    );
endmodule

// File: tb/tb_wb_npu_mailbox.sv
// Mailbox bench: queue-based reference model checked every cycle, directed literal checks, random traffic.
module tb_wb_npu_mailbox;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [3:0]  wb_sel = 0;
    logic [31:0] wb_adr = 0, wb_dat_w = 0, wb_dat_r;
    logic        wb_ack, cmd_valid, cmd_ready = 0, res_valid = 0, res_ready, irq;
    logic [31:0] cmd_data, res_data = 0;

    int errors = 0, checks = 0;
    bit rnd_on = 0;

    always #5 clk = ~clk;

    wb_npu_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DATA_W(32)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(wb_stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(wb_we), .wbs_sel_i(wb_sel),
        .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat_w), .wbs_ack_o(wb_ack), .wbs_dat_o(wb_dat_r),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_data_o(cmd_data),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .irq_o(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] cmdq[$], resq[$];
    bit          m_ovf, m_udf, m_irqen, m_irq, m_ack;
    logic [31:0] m_dat;
    logic [1:0]  p_op;
    bit          p_we, p_popok;
    logic [3:0]  p_sel;
    logic [31:0] p_wdat;

    function automatic logic [31:0] status_of(int nc, int nr, bit ovf, bit udf);
        return (32'(nr) << 11) | (32'(nc) << 4) | {28'b0, nr == 0, nc == DEPTH, udf, ovf};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nc, nr;
        bit flush, cpush, rpop, irq_n, ack_n;
        logic [31:0] rdv;
        if (!rst_n) begin
            cmdq.delete(); resq.delete();
            m_ovf = 0; m_udf = 0; m_irqen = 0; m_irq = 0; m_ack = 0; m_dat = 0;
        end else begin
            nc = cmdq.size(); nr = resq.size();
            flush = 0; cpush = 0; rpop = 0; ack_n = 0;
            irq_n = m_irqen && (nr > 0);
            if (m_ack) begin
                case (p_op)
                    2'd0: if (p_we && p_sel == 4'hF) begin
                              if (nc == DEPTH) m_ovf = 1; else cpush = 1;
                          end
                    2'd1: if (!p_we) begin
                              if (p_popok) rpop = 1; else m_udf = 1;
                          end
                    2'd2: if (p_we) begin
                              if (p_wdat[0]) m_ovf = 0;
                              if (p_wdat[1]) m_udf = 0;
                          end
                    default: if (p_we) begin
                              m_irqen = p_wdat[1];
                              flush   = p_wdat[0];
                          end
                endcase
            end else if (wb_cyc && wb_stb && wb_adr[31:4] == BASE[31:4]) begin
                ack_n = 1;
                p_op = wb_adr[3:2]; p_we = wb_we; p_sel = wb_sel; p_wdat = wb_dat_w;
                p_popok = nr > 0;
                case (p_op)
                    2'd0:    rdv = 0;
                    2'd1:    rdv = (nr > 0) ? resq[0] : 32'h0;
                    2'd2:    rdv = status_of(nc, nr, m_ovf, m_udf);
                    default: rdv = {30'b0, m_irqen, 1'b0};
                endcase
                m_dat = p_we ? 32'h0 : rdv;
            end
            if (flush) begin
                cmdq.delete(); resq.delete();
            end else begin
                if (nc > 0 && cmd_ready) void'(cmdq.pop_front());
                if (cpush) cmdq.push_back(p_wdat);
                if (rpop) void'(resq.pop_front());
                if (nr < DEPTH && res_valid) resq.push_back(res_data);
            end
            m_irq = irq_n;
            m_ack = ack_n;
        end
    end

    // Per-cycle comparison of every observable output against the model.
    always @(posedge clk) begin
        #1;
        chk("ack", 32'(wb_ack), 32'(m_ack));
        chk("cmd_valid", 32'(cmd_valid), 32'(cmdq.size() > 0));
        if (cmdq.size() > 0) chk("cmd_data", cmd_data, cmdq[0]);
        chk("res_ready", 32'(res_ready), 32'(resq.size() < DEPTH));
        chk("irq", 32'(irq), 32'(m_irq));
        if (m_ack && !p_we) chk("rdata", wb_dat_r, m_dat);
    end

    // ---------------- bus tasks ----------------
    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        bit got = 0;
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        rdat = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin got = 1; rdat = wb_dat_r; break; end
        end
        chk("ack_seen", 32'(got), 32'(adr[31:4] == BASE[31:4]));
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] d;
        wb_xfer(1, BASE | 32'(off), dat, sel, d);
    endtask

    task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
        wb_xfer(0, BASE | 32'(off), 32'h0, 4'hF, d);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(wb_ack), 0);
        chk("rst_dat", wb_dat_r, 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_res_ready", 32'(res_ready), 1);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1;

        bus_rd(4'h8, v); chk("status_reset", v, 32'h0000_0008);

        bus_wr(4'h0, 32'h11); bus_wr(4'h0, 32'h22); bus_wr(4'h0, 32'h33);
        bus_rd(4'h8, v); chk("status_cnt3", v, 32'h0000_0038);
        @(negedge clk); cmd_ready = 1;
        chk("drain0", cmd_data, 32'h11);
        @(posedge clk); #1 chk("drain1", cmd_data, 32'h22);
        @(posedge clk); #1 chk("drain2", cmd_data, 32'h33);
        @(posedge clk); #1 chk("drain_done", 32'(cmd_valid), 0);
        @(negedge clk); cmd_ready = 0;

        bus_wr(4'h0, 32'h0000_0F00, 4'h3);
        bus_rd(4'h8, v); chk("partial_sel_dropped", v, 32'h0000_0008);

        for (int i = 0; i < DEPTH; i++) bus_wr(4'h0, 32'h100 + i);
        bus_wr(4'h0, 32'hAA);
        bus_rd(4'h8, v); chk("status_ovf_full", v, 32'h0000_008D);
        bus_wr(4'h8, 32'h1);
        bus_rd(4'h8, v); chk("status_ovf_clr", v, 32'h0000_008C);
        bus_wr(4'hC, 32'h1);
        bus_rd(4'h8, v); chk("status_flush_cmd", v, 32'h0000_0008);

        bus_wr(4'hC, 32'h2);
        @(negedge clk); res_valid = 1; res_data = 32'hCAFE;
        @(posedge clk); #1 chk("irq_plus1", 32'(irq), 0);
        @(negedge clk); res_valid = 0;
        @(posedge clk); #1 chk("irq_plus2", 32'(irq), 1);
        bus_rd(4'h4, v); chk("result_cafe", v, 32'h0000_CAFE);
        repeat (2) @(posedge clk); #1 chk("irq_drop", 32'(irq), 0);
        bus_rd(4'h4, v); chk("result_udf", v, 32'h0);
        bus_rd(4'h8, v); chk("status_udf", v, 32'h0000_000A);

        @(negedge clk); res_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin res_data = $urandom; @(negedge clk); end
        chk("res_full_ready", 32'(res_ready), 0);
        bus_rd(4'h8, v); chk("status_res_full", v, 32'h0000_4002);
        bus_wr(4'hC, 32'h3);
        @(posedge clk); #1 chk("flush_ready", 32'(res_ready), 1);
        @(negedge clk); res_valid = 0;
        bus_rd(4'h8, v); chk("status_flushed", v, 32'h0000_000A);

        @(negedge clk); wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = BASE | 32'h8;
        n = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (wb_ack) n++; end
        @(negedge clk); wb_cyc = 0; wb_stb = 0;
        chk("held_stb_acks", 32'(n), 3);

        bus_wr(4'h0, 32'h55);
        @(negedge clk); wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = BASE; wb_dat_w = 32'h66; wb_sel = 4'hF;
        #2 rst_n = 0;
        @(posedge clk); #1 chk("rst_mid_ack", 32'(wb_ack), 0);
        chk("rst_mid_cmd_valid", 32'(cmd_valid), 0);
        @(negedge clk); wb_cyc = 0; wb_stb = 0; wb_we = 0; rst_n = 1;
        bus_rd(4'h8, v); chk("status_after_rst", v, 32'h0000_0008);

        // Random traffic: first phase favours full/ovf, second favours empty/udf.
        bus_wr(4'hC, 32'h2);
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(negedge clk);
                cmd_ready = (n < 100) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
                res_valid = (n < 100) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
                res_data  = $urandom;
            end
        join_none
        for (n = 0; n < 200; n++) begin
            int r;
            r = $urandom % 16;
            if (r <= 5)       bus_wr(4'h0, $urandom, (r == 5) ? 4'h7 : 4'hF);
            else if (r <= 9)  bus_rd(4'h4, v);
            else if (r <= 11) bus_rd(4'h8, v);
            else if (r == 12) bus_wr(4'h8, $urandom);
            else if (r == 13) bus_wr(4'hC, ($urandom & 32'hFFFF_FFFE) | 32'($urandom % 4 == 0));
            else if (r == 14) begin
                if ($urandom % 2) bus_rd(4'hC, v); else bus_wr(4'h4, $urandom);
            end else
                wb_xfer($urandom % 2, BASE ^ (32'h10 << $urandom_range(0, 27)), $urandom, 4'hF, v);
        end
        rnd_on = 0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
